bcd_string_unit: RTL
====================

# bcd_string_unit

Multi-cycle sequencer for the packed-BCD string instructions ADD4S, SUB4S and CMP4S. It sits directly around the combinational `alu`. It fetches source and destination bytes over a byte memory port, then makes two ALU passes per byte: ADDC/SUBC, then ADJ4A/ADJ4S. It writes the adjusted byte back and returns final CY/Z to the execution unit. IX, IY and CL are inputs only; they are never modified.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request, sampled only in IDLE.
- `op`  in  2  operation: 0=ADD4S, 1=SUB4S, 2=CMP4S, 3=reserved (treated as CMP4S).
- `cl`  in  8  digit count; byte count n = (cl+1)>>1, range 0..128.
- `ix`  in  16  source offset (DS segment).
- `iy`  in  16  destination offset (ES segment).
- `flags_in`  in  flags_t  current PSW, latched at start.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `flags_out`  out  flags_t  latched flags_in with CY and Z replaced; valid when done=1 and held until the next start.
- `mem_req`  out  1  memory request.
- `mem_wr`  out  1  1=write, 0=read.
- `mem_seg`  out  1  0=DS (source), 1=ES (destination).
- `mem_addr`  out  16  byte offset.
- `mem_wdata`  out  8  write data.
- `mem_ack`  in  1  transaction complete this cycle.
- `mem_rdata`  in  8  read data, valid with mem_ack.
- `alu_operation`  out  alu_operation_e  to ALU.
- `alu_ta`, `alu_tb`  out  16  ALU operands; the upper byte is always 0.
- `alu_wide`  out  1  constant 0.
- `alu_flags_in`  out  flags_t  flags presented to the ALU.
- `alu_result`  in  16  ALU result; only [7:0] is used.
- `alu_flags`  in  flags_t  ALU flag output.

## Operation
- **States:** IDLE, RD_SRC, RD_DST, ARITH, ADJ, WR_DST, FIN.
- **Start:**
  - IDLE + start=1: latch op, ix, iy, flags_in and n; clear byte index i=0, carry c=0 and nonzero flag nz=0.
  - Go to FIN if n==0, else to RD_SRC.
- **RD_SRC:** mem_req=1, wr=0, seg=0, addr=ix+i (16-bit wrap). On ack, capture s=rdata and go to RD_DST.
- **RD_DST:** seg=1, addr=iy+i. On ack, capture d=rdata and go to ARITH.
- **ARITH:**
  - alu_ta=d, alu_tb=s, alu_flags_in = latched flags with CY=c.
  - Operation is ADDC for ADD4S, SUBC otherwise.
  - Capture t=alu_result[7:0] and f=alu_flags; go to ADJ.
- **ADJ:**
  - alu_ta=t, alu_flags_in=f; operation is ADJ4A for ADD4S, ADJ4S otherwise.
  - Capture r=alu_result[7:0] and c=alu_flags.CY; set nz |= (r!=0).
  - CMP4S: advance to the next byte. Others: go to WR_DST.
- **WR_DST:** mem_req=1, wr=1, seg=1, addr=iy+i, wdata=r. On ack, advance.
- **Advance:** i=i+1; go to FIN if i==n, else to RD_SRC.
- **FIN:** done=1, busy=1; flags_out = latched flags with CY=c and Z=~nz. Go to IDLE.
- **Ignored / don't-care inputs:**
  - flags_in.CY does not seed the chain; c always starts at 0.
  - Other flags pass through unchanged.
  - start outside IDLE is ignored.
  - mem_ack while mem_req=0 is ignored.
- **ALU idle drive:** outside ARITH/ADJ, alu_operation=ALU_OP_ADDC, alu_ta=alu_tb=0, alu_flags_in=0. The result is discarded.

## Timing
- **Reset values:** busy=0, done=0, mem_req=0, mem_wr=0, mem_seg=0, mem_addr=0, mem_wdata=0, flags_out=0; state=IDLE.
- **Registered outputs:** state and all memory outputs. The ALU path is combinational within ARITH and ADJ, one cycle each.
- **busy:** high from the cycle after start is accepted through FIN inclusive.
- **Memory handshake:** mem_req, wr, seg, addr and wdata stay stable from state entry until the cycle mem_ack=1. Same-cycle ack is allowed. mem_req drops the following cycle unless the next state also requests.
- **Latency with zero-wait memory:**
  - 5 cycles per byte for ADD4S/SUB4S, 4 for CMP4S.
  - done rises 1+5n cycles (or 1+4n) after the start cycle.
  - n=0: done in cycle 1.
  - Each memory wait cycle adds exactly one cycle.
- **Reset mid-operation:** next cycle is IDLE with mem_req=0 and no partial write issued. A write already acked stays written.
- **Back-to-back:** start may be asserted in the IDLE cycle after FIN.

## Test plan
- **ADD4S multi-byte carry:** cl=4, ix=0x0100 holds {0x34,0x12}, iy=0x0200 holds {0x66,0x88} -> ES:0x0200={0x00,0x01}, CY=1, Z=0, done at cycle 11.
- **SUB4S borrow:** cl=2, src={0x01}, dst={0x00} -> dst byte=0x99, CY=1, Z=0.
- **CMP4S equal, source wrap:** cl=3, ix=0xFFFF (reads 0xFFFF then 0x0000), both strings {0x45,0x23} -> mem_wr never 1, Z=1, CY=0, done at cycle 9, memory unchanged.
- **Zero count:** cl=0 -> no mem_req, done at cycle 1, Z=1, CY=0; flags_in.S/V/P pass through unchanged.
- **Wait states:** mem_ack delayed 3 cycles on every RD_DST of a 2-byte ADD4S -> addr/seg/req held stable throughout; done 6 cycles later than the zero-wait case; same result.
- **Reset mid-operation:** reset during ADJ of byte 0 -> next cycle busy=0, mem_req=0, destination unmodified. A following start with cl=2 completes normally.

Source files
------------

// File: rtl/bcd_string_unit.sv
// Packed-BCD string sequencer (ADD4S/SUB4S/CMP4S) wrapped around a combinational ALU.
// Flags: CY=bit0, AF=bit4, Z=bit6. ALU opcodes: ADDC=0, SUBC=1, ADJ4A=2, ADJ4S=3.
module bcd_string_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [7:0]  cl,
  input  logic [15:0] ix,
  input  logic [15:0] iy,
  input  logic [15:0] flags_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] flags_out,
  output logic        mem_req,
  output logic        mem_wr,
  output logic        mem_seg,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [3:0]  alu_operation,
  output logic [15:0] alu_ta,
  output logic [15:0] alu_tb,
  output logic        alu_wide,
  output logic [15:0] alu_flags_in,
  input  logic [15:0] alu_result,
  input  logic [15:0] alu_flags
);

  localparam logic [3:0] ALU_OP_ADDC  = 4'd0;
  localparam logic [3:0] ALU_OP_SUBC  = 4'd1;
  localparam logic [3:0] ALU_OP_ADJ4A = 4'd2;
  localparam logic [3:0] ALU_OP_ADJ4S = 4'd3;
  localparam int CY_BIT = 0;
  localparam int Z_BIT  = 6;

  typedef enum logic [2:0] {
    IDLE, RD_SRC, RD_DST, ARITH, ADJ, WR_DST, FIN
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] ix_q, ix_d, iy_q, iy_d, flags_q, flags_d, f_q, f_d;
  logic [7:0]  n_q, n_d, i_q, i_d, s_q, s_d, d_q, d_d, t_q, t_d, r_q, r_d;
  logic        c_q, c_d, nz_q, nz_d;
  logic [15:0] flags_out_q, flags_out_d;
  logic        mem_req_q, mem_req_d, mem_wr_q, mem_wr_d, mem_seg_q, mem_seg_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [8:0]  n_calc;
  logic        is_add, is_cmp;
  logic        unused_alu_hi;

  assign n_calc        = ({1'b0, cl} + 9'd1) >> 1;
  assign is_add        = (op_q == 2'd0);
  assign is_cmp        = op_q[1];
  assign unused_alu_hi = ^alu_result[15:8];

  always_comb begin
    state_d = state_q;
    op_d = op_q; ix_d = ix_q; iy_d = iy_q; flags_d = flags_q; f_d = f_q;
    n_d = n_q; i_d = i_q; s_d = s_q; d_d = d_q; t_d = t_q; r_d = r_q;
    c_d = c_q; nz_d = nz_q;
    flags_out_d   = flags_out_q;
    alu_operation = ALU_OP_ADDC;
    alu_ta        = 16'h0000;
    alu_tb        = 16'h0000;
    alu_flags_in  = 16'h0000;

    case (state_q)
      IDLE: if (start) begin
        op_d = op; ix_d = ix; iy_d = iy; flags_d = flags_in; n_d = n_calc[7:0];
        i_d = 8'd0; c_d = 1'b0; nz_d = 1'b0;
        state_d = (n_calc == 9'd0) ? FIN : RD_SRC;
      end
      RD_SRC: if (mem_ack) begin
        s_d = mem_rdata;
        state_d = RD_DST;
      end
      RD_DST: if (mem_ack) begin
        d_d = mem_rdata;
        state_d = ARITH;
      end
      ARITH: begin
        alu_operation = is_add ? ALU_OP_ADDC : ALU_OP_SUBC;
        alu_ta        = {8'h00, d_q};
        alu_tb        = {8'h00, s_q};
        alu_flags_in  = flags_q;
        alu_flags_in[CY_BIT] = c_q;
        t_d = alu_result[7:0];
        f_d = alu_flags;
        state_d = ADJ;
      end
      ADJ: begin
        alu_operation = is_add ? ALU_OP_ADJ4A : ALU_OP_ADJ4S;
        alu_ta        = {8'h00, t_q};
        alu_flags_in  = f_q;
        r_d  = alu_result[7:0];
        c_d  = alu_flags[CY_BIT];
        nz_d = nz_q | (alu_result[7:0] != 8'h00);
        if (is_cmp) begin
          i_d = i_q + 8'd1;
          state_d = (i_d == n_q) ? FIN : RD_SRC;
        end else begin
          state_d = WR_DST;
        end
      end
      WR_DST: if (mem_ack) begin
        i_d = i_q + 8'd1;
        state_d = (i_d == n_q) ? FIN : RD_SRC;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Result flags are latched on the way into FIN so they stay valid after done.
    if (state_d == FIN && state_q != FIN) begin
      flags_out_d = flags_d;
      flags_out_d[CY_BIT] = c_d;
      flags_out_d[Z_BIT]  = ~nz_d;
    end

    // Memory outputs are derived from the state being entered, so they are registered.
    mem_req_d   = (state_d == RD_SRC) || (state_d == RD_DST) || (state_d == WR_DST);
    mem_wr_d    = (state_d == WR_DST);
    mem_seg_d   = (state_d == RD_DST) || (state_d == WR_DST);
    mem_addr_d  = (state_d == RD_SRC) ? ix_d + {8'h00, i_d} :
                  mem_seg_d           ? iy_d + {8'h00, i_d} : 16'h0000;
    mem_wdata_d = mem_wr_d ? r_d : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= 2'd0; ix_q <= 16'h0; iy_q <= 16'h0; flags_q <= 16'h0; f_q <= 16'h0;
      n_q <= 8'd0; i_q <= 8'd0; s_q <= 8'd0; d_q <= 8'd0; t_q <= 8'd0; r_q <= 8'd0;
      c_q <= 1'b0; nz_q <= 1'b0;
      flags_out_q <= 16'h0;
      mem_req_q <= 1'b0; mem_wr_q <= 1'b0; mem_seg_q <= 1'b0;
      mem_addr_q <= 16'h0; mem_wdata_q <= 8'h0;
    end else begin
      state_q <= state_d;
      op_q <= op_d; ix_q <= ix_d; iy_q <= iy_d; flags_q <= flags_d; f_q <= f_d;
      n_q <= n_d; i_q <= i_d; s_q <= s_d; d_q <= d_d; t_q <= t_d; r_q <= r_d;
      c_q <= c_d; nz_q <= nz_d;
      flags_out_q <= flags_out_d;
      mem_req_q <= mem_req_d; mem_wr_q <= mem_wr_d; mem_seg_q <= mem_seg_d;
      mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign flags_out = flags_out_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_seg   = mem_seg_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign alu_wide  = 1'b0;

endmodule
